// File: rtl/mips_fetch_sequencer.sv
// ============================================================================
// Module   : mips_fetch_sequencer
// Purpose  : Multi-cycle fetch/issue controller feeding a single-cycle MIPS
//            core; optional single-step mode under macro SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_fetch_sequencer #(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] PC_START = '0,
  parameter logic [5:0]          HALT_OP  = 6'h3F,
  parameter logic [31:0]         NOP_WORD = 32'h0000_0000,
  parameter int unsigned         TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic [31:0]         instr_out,
  output logic                issue,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         icount
);

  // Counter value seen in the last FETCH cycle allowed to go without an ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_HALTED    = 3'd3,
`ifdef SINGLE_STEP_EN
    S_STEP_WAIT = 3'd5,
`endif
    S_ERROR     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         icount_q, icount_d;
  logic [31:0]         instr_q, instr_d;
  logic [7:0]          tmo_q, tmo_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_START;
      icount_q <= 16'h0000;
      instr_q  <= NOP_WORD;
      tmo_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      instr_q  <= instr_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    tmo_d    = tmo_q;
    instr_d  = NOP_WORD;

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          pc_d     = PC_START;
          icount_d = 16'h0000;
          tmo_d    = 8'h00;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        if (imem_ack) begin
          tmo_d = 8'h00;
          if (imem_rdata[31:26] == HALT_OP) begin
            state_d = S_HALTED;
          end else begin
            instr_d = imem_rdata;
            state_d = S_ISSUE;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q >= TMO_LAST) begin
            state_d = S_ERROR;
          end
        end
      end

      S_ISSUE: begin
        pc_d = pc_q + PC_WIDTH'(1);
        if (icount_q != 16'hFFFF) begin
          icount_d = icount_q + 16'd1;
        end
`ifdef SINGLE_STEP_EN
        state_d = S_STEP_WAIT;
`else
        state_d = S_FETCH;
`endif
      end

`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign issue     = (state_q == S_ISSUE);
  assign halted    = (state_q == S_HALTED);
  assign err       = (state_q == S_ERROR);
`ifdef SINGLE_STEP_EN
  assign busy      = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                     (state_q == S_STEP_WAIT);
`else
  assign busy      = (state_q == S_FETCH) || (state_q == S_ISSUE);
`endif
  assign pc        = pc_q;
  assign icount    = icount_q;
  assign instr_out = instr_q;

endmodule

`default_nettype wire

// File: doc/mips_fetch_sequencer.md
Name: mips_fetch_sequencer

Overview:
- Multi-cycle instruction fetch/issue controller in front of the MIPS core.
- Fetches instruction words from an instruction memory over a req/ack handshake and presents each word on the core's 32-bit instruction input for exactly one clock.
- Drives a NOP word at all other times, so the single-cycle core advances only on issued instructions.
- Tracks PC, counts retired instructions, stops on a HALT opcode, and flags a memory timeout.

Parameters:
- PC_WIDTH, 8, width of word-addressed PC / imem address.
- PC_START, 0, PC loaded on start.
- HALT_OP, 6'h3F, opcode (bits 31:26) that halts the sequencer.
- NOP_WORD, 32'h00000000, word driven to the core when not issuing.
- TIMEOUT, 15, max FETCH cycles without ack before error; must be 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins execution from PC_START (honoured in IDLE, HALTED, ERROR only).
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  PC_WIDTH  fetch address; equals pc while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  read-data-valid strobe; ignored unless imem_req=1.
- instr_out  out  32  instruction to the MIPS core In port.
- issue  out  1  high for the single cycle instr_out carries a fetched instruction.
- busy  out  1  high in FETCH or ISSUE.
- halted  out  1  high in HALTED.
- err  out  1  high in ERROR.
- pc  out  PC_WIDTH  current PC.
- icount  out  16  issued-instruction counter, saturating.
- step  in  1  single-step advance (present only with SINGLE_STEP_EN).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=PC_START, icount=0, instr_out=NOP_WORD, imem_req=0, issue=0, busy=0, halted=0, err=0, timeout counter=0.
  - Asserting reset mid-operation drops imem_req in the same instant. The fetch in flight is abandoned.
- States: IDLE, FETCH, ISSUE, HALTED, ERROR.
- IDLE / HALTED / ERROR:
  - On start=1: pc<=PC_START, icount<=0, clear the timeout counter, go to FETCH.
  - Without start, hold the current state.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - The timeout counter increments each FETCH cycle without ack.
  - On imem_ack=1: latch imem_rdata into the instruction register and clear the counter.
    - If rdata[31:26]==HALT_OP, go to HALTED. The HALT word is never issued or counted, and pc stays on the HALT address.
    - Otherwise go to ISSUE.
  - If the counter reaches TIMEOUT with no ack, go to ERROR with pc unchanged. An ack in that same cycle takes priority over the timeout.
- ISSUE:
  - For one cycle: instr_out=latched word, issue=1.
  - pc<=pc+1, wrapping modulo 2^PC_WIDTH (max→0, no flag).
  - icount<=icount+1, saturating at 16'hFFFF.
  - Next state is FETCH.
- instr_out=NOP_WORD in every state except ISSUE. instr_out is registered.
- start outside IDLE/HALTED/ERROR is ignored.
- Timing:
  - An ack in cycle t gives issue=1 in cycle t+1.
  - The next imem_req rises in cycle t+2.
  - Minimum 2 cycles per instruction (ack held high).
- Outputs halted, err and busy are decoded directly from state.
- imem_ack while imem_req=0 has no effect.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - The step port exists.
  - After each ISSUE, the FSM enters a STEP_WAIT state (busy=1, imem_req=0, instr_out=NOP_WORD) and goes to FETCH only on step=1.
  - step=1 during the ISSUE cycle itself is not remembered.
  - start is ignored in STEP_WAIT.
- Undefined: no step port, no STEP_WAIT state; ISSUE goes directly to FETCH.

Test Plan:
- Reset, then start. Memory returns 3 words with ack in the same cycle as req: {32'h20080005, 32'h20090003, 32'hFC000000}.
  - Required: issue pulses exactly twice, with instr_out=20080005 then 20090003, 2 cycles apart.
  - Required: halted=1 with pc=2 and icount=2.
  - Required: instr_out=00000000 outside the issue cycles.
- Memory acks 4 cycles after req rises.
  - Required: imem_req held high with imem_addr stable for 4 cycles; issue occurs exactly 1 cycle after ack.
- Memory never acks (TIMEOUT=15).
  - Required: err=1 on the 16th cycle after FETCH entry; imem_req=0 thereafter; pc unchanged.
  - Required: a subsequent start clears err and fetches from pc=0.
- PC_WIDTH=2, no HALT word in memory.
  - Required: pc sequence 0,1,2,3,0,1 across issues.
  - Separately, with icount forced near saturation: icount stops at FFFF.
- Drive reset=0 asynchronously mid-FETCH while imem_req=1.
  - Required: imem_req=0, busy=0, pc=0, icount=0 immediately, before the next clk edge.
- With SINGLE_STEP_EN: after start, exactly one issue occurs, then busy=1 and imem_req=0 until step=1.
  - Required: each step pulse yields exactly one further issue.
  - Required: start in STEP_WAIT has no effect.
